signed_product_accumulator: RTL and testbench



---
 rtl/signed_product_accumulator.sv | 152 +++++++++++++++
 tb/tb_signed_product_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_product_accumulator.sv
// signed_product_accumulator
// Accumulates a programmed number of signed multiplier products into a wide
// accumulator (dot product). A product is captured on the rising edge of
// prod_valid, so a level held high counts once. The block reports the sum,
// a one-cycle done pulse and a sticky signed-overflow flag.
//
// Optional build macro: PROD_ACC_SATURATE_EN
//   undefined : an overflowing add wraps (two's complement), ovf is set
//   defined   : an overflowing add clamps to the most positive/negative value
//
// state | meaning
// IDLE  | waiting for start; acc_out holds the last result
// ACCUM | summing products, one per prod_valid rising edge
// DONE  | result final; done is high for exactly this cycle
module signed_product_accumulator #(
    parameter int WIDTH   = 12,
    parameter int GUARD   = 4,
    parameter int TERMS_W = 8,
    localparam int PROD_W = 2 * WIDTH,
    localparam int ACC_W  = 2 * WIDTH + GUARD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [TERMS_W-1:0]  num_terms,
    input  logic                prod_valid,
    input  logic [PROD_W-1:0]   prod,
    output logic [ACC_W-1:0]    acc_out,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [TERMS_W-1:0]   count_q, count_d;
    logic [TERMS_W-1:0]   num_terms_q, num_terms_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 prev_valid_q, prev_valid_d;

    logic                 capture;
    logic [ACC_W-1:0]     prod_ext;
    logic [ACC_W-1:0]     sum;
    logic                 add_ovf;
    logic [ACC_W-1:0]     add_result;
    logic [TERMS_W-1:0]   count_inc;

    // Rising-edge detect on prod_valid and the full-width signed add.
    always_comb begin
        prev_valid_d = prod_valid;
        capture      = prod_valid & ~prev_valid_q;
        prod_ext     = {{GUARD{prod[PROD_W-1]}}, prod};
        sum          = acc_q + prod_ext;
        // Same-sign operands producing an opposite-sign result.
        add_ovf      = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                       (sum[ACC_W-1] != acc_q[ACC_W-1]);
        count_inc    = count_q + 1'b1;
`ifdef PROD_ACC_SATURATE_EN
        // Overflow direction follows the (shared) operand sign.
        if (add_ovf) begin
            add_result = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_result = sum;
        end
`else
        add_result = sum;
`endif
    end

    // Next-state and datapath update for the IDLE/ACCUM/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        num_terms_d = num_terms_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    if (num_terms != '0) begin
                        num_terms_d = num_terms;
                        state_d     = ACCUM;
                    end else begin
                        // Zero-length run completes immediately with a zero sum.
                        state_d = DONE;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (capture) begin
                    acc_d   = add_result;
                    ovf_d   = ovf_q | add_ovf;
                    count_d = count_inc;
                    if (count_inc == num_terms_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered alongside the state they describe.
        busy_d = (state_d == ACCUM);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            num_terms_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            num_terms_q  <= num_terms_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign acc_out = acc_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_signed_product_accumulator.sv
module tb_signed_product_accumulator;

    localparam int WIDTH   = 12;
    localparam int GUARD   = 4;
    localparam int TERMS_W = 8;
    localparam int PROD_W  = 2 * WIDTH;
    localparam int ACC_W   = 2 * WIDTH + GUARD;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [TERMS_W-1:0]  num_terms;
    logic                prod_valid;
    logic [PROD_W-1:0]   prod;
    logic [ACC_W-1:0]    acc_out;
    logic                busy;
    logic                done;
    logic                ovf;

    signed_product_accumulator #(
        .WIDTH   (WIDTH),
        .GUARD   (GUARD),
        .TERMS_W (TERMS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_terms  (num_terms),
        .prod_valid (prod_valid),
        .prod       (prod),
        .acc_out    (acc_out),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        int     n;
        longint p0, p1, p2, p3;
        longint exp_acc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        start     = 1'b1;
        num_terms = n[TERMS_W-1:0];
        tick();
        start     = 1'b0;
    endtask

    // One-cycle valid pulse; returns just after the edge that samples it.
    task automatic pulse(input longint p);
        prod       = p[PROD_W-1:0];
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    function automatic longint sacc();
        return longint'($signed(acc_out));
    endfunction

    initial begin
        longint ps[4];
        longint held;
        int     d0;

        vecs[0] = '{n: 3, p0: 6,        p1: -20,      p2: 100,      p3: 0, exp_acc: 86};
        vecs[1] = '{n: 1, p0: -7,       p1: 0,        p2: 0,        p3: 0, exp_acc: -7};
        vecs[2] = '{n: 4, p0: 8388607,  p1: 8388607,  p2: -8388608, p3: 1, exp_acc: 8388607};
        vecs[3] = '{n: 2, p0: -8388608, p1: -8388608, p2: 0,        p3: 0, exp_acc: -16777216};
        vecs[4] = '{n: 4, p0: -1,       p1: -1,       p2: -1,       p3: 5, exp_acc: 2};

        rst_n      = 1'b0;
        start      = 1'b0;
        num_terms  = '0;
        prod_valid = 1'b0;
        prod       = '0;

        // Reset with prod_valid toggling.
        prod = 24'd1234;
        tick();
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        check("reset_acc",  sacc(), 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ovf",  ovf, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_acc", sacc(), 0);

        // Table-driven runs with one-cycle pulses.
        for (int v = 0; v < 5; v++) begin
            ps[0] = vecs[v].p0; ps[1] = vecs[v].p1;
            ps[2] = vecs[v].p2; ps[3] = vecs[v].p3;
            start_run(vecs[v].n);
            check($sformatf("v%0d_busy_start", v), busy, 1);
            for (int j = 0; j < vecs[v].n; j++) begin
                pulse(ps[j]);
                if (j == vecs[v].n - 1) begin
                    check($sformatf("v%0d_done", v), done, 1);
                    check($sformatf("v%0d_busy_end", v), busy, 0);
                    check($sformatf("v%0d_acc", v), sacc(), vecs[v].exp_acc);
                    check($sformatf("v%0d_ovf", v), ovf, 0);
                end else begin
                    check($sformatf("v%0d_nodone", v), done, 0);
                end
                tick();
            end
            check($sformatf("v%0d_done_low", v), done, 0);
            check($sformatf("v%0d_acc_hold", v), sacc(), vecs[v].exp_acc);
        end

        // Capture in IDLE is ignored.
        held = sacc();
        pulse(999);
        tick();
        check("idle_capture_ignored", sacc(), held);

        // Level valid: two long levels count as two captures.
        d0 = done_cnt;
        start_run(2);
        prod       = 24'd4194304;
        prod_valid = 1'b1;
        repeat (5) tick();
        prod_valid = 1'b0;
        check("level_first_acc", sacc(), 4194304);
        check("level_busy", busy, 1);
        tick();
        prod       = 24'hC00000;
        prod_valid = 1'b1;
        tick();
        check("level_done", done, 1);
        check("level_acc", sacc(), 0);
        repeat (2) tick();
        prod_valid = 1'b0;
        tick();
        check("level_done_count", done_cnt - d0, 1);
        check("level_acc_hold", sacc(), 0);

        // Level already high at start is not counted until it re-rises.
        prod       = 24'd100;
        prod_valid = 1'b1;
        tick();
        start_run(1);
        tick();
        tick();
        check("prehigh_acc", sacc(), 0);
        check("prehigh_busy", busy, 1);
        prod_valid = 1'b0;
        tick();
        prod_valid = 1'b1;
        tick();
        check("prehigh_done", done, 1);
        check("prehigh_acc_final", sacc(), 100);
        prod_valid = 1'b0;
        tick();

        // Zero terms: done next cycle, busy never rises.
        start_run(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_acc", sacc(), 0);
        tick();
        check("zero_done_low", done, 0);

        // Start during ACCUM is ignored.
        start_run(2);
        pulse(10);
        tick();
        start     = 1'b1;
        num_terms = 8'd5;
        tick();
        start     = 1'b0;
        check("ign_start_busy", busy, 1);
        pulse(20);
        check("ign_start_done", done, 1);
        check("ign_start_acc", sacc(), 30);
        tick();

        // Overflow: 32 x 2^22 = 2^27 exceeds the 28-bit signed range.
        start_run(32);
        for (int i = 0; i < 32; i++) begin
            pulse(4194304);
            if (i == 30) check("ovf_not_yet", ovf, 0);
            if (i == 31) begin
                check("ovf_done", done, 1);
                check("ovf_flag", ovf, 1);
`ifdef PROD_ACC_SATURATE_EN
                check("ovf_acc_sat", sacc(), 134217727);
`else
                check("ovf_acc_wrap", sacc(), -134217728);
`endif
            end
            tick();
        end
        check("ovf_sticky_idle", ovf, 1);
        start_run(1);
        check("ovf_cleared_on_start", ovf, 0);
        check("acc_cleared_on_start", sacc(), 0);
        pulse(3);
        check("after_ovf_acc", sacc(), 3);
        tick();

        // Reset mid-accumulation discards the partial sum.
        start_run(4);
        pulse(5);
        tick();
        pulse(6);
        tick();
        check("mid_partial_acc", sacc(), 11);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_acc",  sacc(), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ovf",  ovf, 0);
        tick();
        start_run(1);
        pulse(-7);
        check("mid_rst_new_done", done, 1);
        check("mid_rst_new_acc", sacc(), -7);
        tick();
        check("mid_rst_new_done_low", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
